// File: rtl/dc_tagcheck_rrip.sv
// Set-associative tag-check engine for the L1 data cache with RRIP replacement.
// Ways of the indexed set are scanned one per cycle: a hit returns the matching way,
// a miss picks the first way that is Invalid or at RRPV_MAX, aging the set until one exists.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   req_*             lookup request (valid/retry handshake, index, tag)
//   ack_*             lookup result (valid/retry handshake, hit, way, state, victim tag)
//   fill_*            tag install from the L2 ack path (index, way, tag, state)
module dc_tagcheck_rrip #(
  parameter int unsigned WAYS       = 8,
  parameter int unsigned SETS       = 32,
  parameter int unsigned TAG_BITS   = 10,
  parameter int unsigned STATE_BITS = 3,
  parameter int unsigned RRPV_BITS  = 2,
  parameter int unsigned STATE_I    = 0,
  localparam int unsigned WAY_BITS  = $clog2(WAYS),
  localparam int unsigned IDX_BITS  = $clog2(SETS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_retry,
  input  logic [IDX_BITS-1:0]   req_index,
  input  logic [TAG_BITS-1:0]   req_tag,
  output logic                  ack_valid,
  input  logic                  ack_retry,
  output logic                  ack_hit,
  output logic [WAY_BITS-1:0]   ack_way,
  output logic [STATE_BITS-1:0] ack_state,
  output logic [TAG_BITS-1:0]   ack_victim_tag,
  input  logic                  fill_valid,
  output logic                  fill_retry,
  input  logic [IDX_BITS-1:0]   fill_index,
  input  logic [WAY_BITS-1:0]   fill_way,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [STATE_BITS-1:0] fill_state
);

  localparam logic [RRPV_BITS-1:0]  RrpvMax  = '1;
  localparam logic [RRPV_BITS-1:0]  RrpvIns  = RrpvMax - RRPV_BITS'(1);
  localparam logic [STATE_BITS-1:0] StateInv = STATE_BITS'(STATE_I);
  localparam logic [WAY_BITS-1:0]   LastWay  = WAY_BITS'(WAYS - 1);

  typedef enum logic [2:0] {StIdle, StLookup, StVictim, StAge, StResp} fsm_e;

  fsm_e r_fsm, w_fsm_d;

  logic [TAG_BITS-1:0]   r_tags  [SETS][WAYS];
  logic [STATE_BITS-1:0] r_states[SETS][WAYS];
  logic [RRPV_BITS-1:0]  r_rrpv  [SETS][WAYS];

  logic [IDX_BITS-1:0]   r_req_idx;
  logic [TAG_BITS-1:0]   r_req_tag;
  logic [WAY_BITS-1:0]   r_way_cnt, w_way_cnt_d;

  logic                  r_ack_hit;
  logic [WAY_BITS-1:0]   r_ack_way;
  logic [STATE_BITS-1:0] r_ack_state;
  logic [TAG_BITS-1:0]   r_ack_vtag;

  logic [TAG_BITS-1:0]   w_cur_tag;
  logic [STATE_BITS-1:0] w_cur_state;
  logic [RRPV_BITS-1:0]  w_cur_rrpv;
  logic                  w_hit, w_vic, w_last;
  logic                  w_req_acc, w_fill_acc, w_cap, w_set_mru, w_age;

  // The way currently under examination in the latched set.
  assign w_cur_tag   = r_tags[r_req_idx][r_way_cnt];
  assign w_cur_state = r_states[r_req_idx][r_way_cnt];
  assign w_cur_rrpv  = r_rrpv[r_req_idx][r_way_cnt];
  // A tag match on an Invalid way never counts as a hit.
  assign w_hit  = (w_cur_state != StateInv) && (w_cur_tag == r_req_tag);
  assign w_vic  = (w_cur_state == StateInv) || (w_cur_rrpv == RrpvMax);
  assign w_last = (r_way_cnt == LastWay);

  assign req_retry      = (r_fsm != StIdle) | fill_valid;
  assign fill_retry     = (r_fsm != StIdle);
  assign ack_valid      = (r_fsm == StResp);
  assign ack_hit        = r_ack_hit;
  assign ack_way        = r_ack_way;
  assign ack_state      = r_ack_state;
  assign ack_victim_tag = r_ack_vtag;

  always_comb begin
    w_fsm_d     = r_fsm;
    w_way_cnt_d = r_way_cnt;
    w_req_acc   = 1'b0;
    w_fill_acc  = 1'b0;
    w_cap       = 1'b0;
    w_set_mru   = 1'b0;
    w_age       = 1'b0;
    unique case (r_fsm)
      StIdle: begin
        if (fill_valid) begin
          w_fill_acc = 1'b1;
        end else if (req_valid) begin
          w_req_acc   = 1'b1;
          w_way_cnt_d = '0;
          w_fsm_d     = StLookup;
        end
      end
      StLookup: begin
        if (w_hit) begin
          w_cap     = 1'b1;
          w_set_mru = 1'b1;
          w_fsm_d   = StResp;
        end else if (w_last) begin
          w_way_cnt_d = '0;
          w_fsm_d     = StVictim;
        end else begin
          w_way_cnt_d = r_way_cnt + WAY_BITS'(1);
        end
      end
      StVictim: begin
        if (w_vic) begin
          w_cap   = 1'b1;
          w_fsm_d = StResp;
        end else if (w_last) begin
          w_fsm_d = StAge;
        end else begin
          w_way_cnt_d = r_way_cnt + WAY_BITS'(1);
        end
      end
      StAge: begin
        w_age       = 1'b1;
        w_way_cnt_d = '0;
        w_fsm_d     = StVictim;
      end
      StResp: begin
        if (!ack_retry) w_fsm_d = StIdle;
      end
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm       <= StIdle;
      r_way_cnt   <= '0;
      r_req_idx   <= '0;
      r_req_tag   <= '0;
      r_ack_hit   <= 1'b0;
      r_ack_way   <= '0;
      r_ack_state <= '0;
      r_ack_vtag  <= '0;
    end else begin
      r_fsm     <= w_fsm_d;
      r_way_cnt <= w_way_cnt_d;
      if (w_req_acc) begin
        r_req_idx <= req_index;
        r_req_tag <= req_tag;
      end
      if (w_cap) begin
        r_ack_hit   <= (r_fsm == StLookup);
        r_ack_way   <= r_way_cnt;
        r_ack_state <= w_cur_state;
        r_ack_vtag  <= w_cur_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_tags[s][w]   <= '0;
          r_states[s][w] <= StateInv;
          r_rrpv[s][w]   <= RrpvMax;
        end
      end
    end else begin
      if (w_fill_acc) begin
        r_tags[fill_index][fill_way]   <= fill_tag;
        r_states[fill_index][fill_way] <= fill_state;
        r_rrpv[fill_index][fill_way]   <= RrpvIns;
      end
      if (w_set_mru) r_rrpv[r_req_idx][r_way_cnt] <= '0;
      if (w_age) begin
        for (int w = 0; w < WAYS; w++) begin
          if (r_rrpv[r_req_idx][w] != RrpvMax) begin
            r_rrpv[r_req_idx][w] <= r_rrpv[r_req_idx][w] + RRPV_BITS'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dc_tagcheck_rrip.sv
// Directed bench for dc_tagcheck_rrip: a set-level replacement model predicts hit/victim
// and latency; a negedge compare process checks handshakes and ack fields every cycle.
module tb_dc_tagcheck_rrip;

  localparam int WAYS = 8;
  localparam int SETS = 32;
  localparam int WB   = 3;
  localparam int IB   = 5;
  localparam int RMAX = 3;

  logic          clk, reset;
  logic          req_valid, req_retry;
  logic [IB-1:0] req_index;
  logic [9:0]    req_tag;
  logic          ack_valid, ack_retry, ack_hit;
  logic [WB-1:0] ack_way;
  logic [2:0]    ack_state;
  logic [9:0]    ack_victim_tag;
  logic          fill_valid, fill_retry;
  logic [IB-1:0] fill_index;
  logic [WB-1:0] fill_way;
  logic [9:0]    fill_tag;
  logic [2:0]    fill_state;

  dc_tagcheck_rrip dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_retry(req_retry), .req_index(req_index), .req_tag(req_tag),
    .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_hit(ack_hit), .ack_way(ack_way),
    .ack_state(ack_state), .ack_victim_tag(ack_victim_tag),
    .fill_valid(fill_valid), .fill_retry(fill_retry), .fill_index(fill_index),
    .fill_way(fill_way), .fill_tag(fill_tag), .fill_state(fill_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model of the cache contents
  int m_tag  [SETS][WAYS];
  int m_st   [SETS][WAYS];
  int m_rrpv [SETS][WAYS];

  // Expected transaction
  bit m_busy  = 1'b0;
  int n_since = 0;
  int exp_lat, exp_hit, exp_way, exp_state, exp_vtag;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = 0; m_st[s][w] = 0; m_rrpv[s][w] = RMAX;
      end
  endtask

  // Hit: first valid way with matching tag. Miss: repeatedly look for an Invalid or
  // max-RRPV way; if none, age the whole set and try again.
  task automatic model_lookup(input int idx, input int tag);
    int v, passes;
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (v < 0 && m_st[idx][w] != 0 && m_tag[idx][w] == tag) v = w;
    if (v >= 0) begin
      exp_hit = 1; exp_way = v; exp_state = m_st[idx][v]; exp_vtag = tag;
      exp_lat = v + 1;
      m_rrpv[idx][v] = 0;
    end else begin
      passes = 0;
      while (v < 0 && passes < 10) begin
        for (int w = 0; w < WAYS; w++)
          if (v < 0 && (m_st[idx][w] == 0 || m_rrpv[idx][w] == RMAX)) v = w;
        if (v < 0) begin
          for (int w = 0; w < WAYS; w++)
            if (m_rrpv[idx][w] < RMAX) m_rrpv[idx][w] = m_rrpv[idx][w] + 1;
          passes++;
        end
      end
      exp_hit = 0; exp_way = v; exp_state = m_st[idx][v]; exp_vtag = m_tag[idx][v];
      // full lookup scan, then one full victim scan plus an age cycle per pass
      exp_lat = WAYS + passes * (WAYS + 1) + v + 1;
    end
  endtask

  always @(negedge clk) begin
    if (m_busy) begin
      chk("ack_valid", int'(ack_valid), int'(n_since >= exp_lat));
      chk("req_retry_busy", int'(req_retry), 1);
      chk("fill_retry_busy", int'(fill_retry), 1);
      if (ack_valid) begin
        chk("ack_hit", int'(ack_hit), exp_hit);
        chk("ack_way", int'(ack_way), exp_way);
        chk("ack_state", int'(ack_state), exp_state);
        if (exp_hit == 0 && exp_state != 0)
          chk("ack_victim_tag", int'(ack_victim_tag), exp_vtag);
      end
      n_since++;
    end else begin
      chk("ack_valid_idle", int'(ack_valid), 0);
      chk("req_retry_idle", int'(req_retry), int'(fill_valid));
      chk("fill_retry_idle", int'(fill_retry), 0);
    end
  end

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  endtask

  task automatic do_fill(input int idx, input int way, input int tag, input int st);
    fill_valid = 1'b1;
    fill_index = IB'(idx); fill_way = WB'(way); fill_tag = 10'(tag); fill_state = 3'(st);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    m_tag[idx][way] = tag; m_st[idx][way] = st; m_rrpv[idx][way] = RMAX - 1;
  endtask

  // lit_* pin the model against hand-computed values (-1 = not pinned).
  task automatic do_req(input int idx, input int tag, input int hold,
                        input int lit_hit, input int lit_way, input int lit_lat,
                        input int lit_vtag);
    bit got;
    model_lookup(idx, tag);
    chk("model_hit", exp_hit, lit_hit);
    chk("model_way", exp_way, lit_way);
    chk("model_lat", exp_lat, lit_lat);
    if (lit_vtag >= 0) chk("model_vtag", exp_vtag, lit_vtag);
    req_valid = 1'b1; req_index = IB'(idx); req_tag = 10'(tag);
    ack_retry = (hold > 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_busy = 1'b1; n_since = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (ack_valid) got = 1'b1;
    end
    if (!got) begin
      n_vec++; n_miss++;
      $display("FAIL ack_timeout: got no ack expected ack within 100 cycles");
      finish_now();
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    ack_retry = 1'b0;
    @(posedge clk); #1;
    m_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_index = '0; req_tag = '0; ack_retry = 1'b0;
    fill_valid = 1'b0; fill_index = '0; fill_way = '0; fill_tag = '0; fill_state = '0;
    model_reset();
    #12;
    chk("rst_ack_valid", int'(ack_valid), 0);
    chk("rst_ack_hit", int'(ack_hit), 0);
    chk("rst_ack_way", int'(ack_way), 0);
    chk("rst_ack_state", int'(ack_state), 0);
    chk("rst_ack_vtag", int'(ack_victim_tag), 0);
    chk("rst_req_retry", int'(req_retry), 0);
    chk("rst_fill_retry", int'(fill_retry), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Cold miss: first Invalid way
    do_req(3, 'h155, 0, 0, 0, 9, -1);
    // Fill then hit in way 5
    do_fill(3, 5, 'h155, 1);
    do_req(3, 'h155, 0, 1, 5, 6, -1);
    chk("model_rrpv_hit", m_rrpv[3][5], 0);

    // Full set at RRPV 2: one aging pass, victim way 0
    for (int w = 0; w < WAYS; w++) do_fill(7, w, 'h10 + w, 1);
    do_req(7, 'h3FF, 0, 0, 0, 18, 'h10);
    for (int w = 0; w < WAYS; w++) chk("model_rrpv_aged", m_rrpv[7][w], 3);

    // Same set with way 2 recently hit
    for (int w = 0; w < WAYS; w++) do_fill(7, w, 'h10 + w, 1);
    do_req(7, 'h12, 0, 1, 2, 3, -1);
    do_req(7, 'h3FF, 0, 0, 0, 18, 'h10);
    chk("model_rrpv_w2", m_rrpv[7][2], 1);
    chk("model_rrpv_w1", m_rrpv[7][1], 3);
    // Victim RRPV left at max: immediate victim
    do_req(7, 'h3FF, 0, 0, 0, 9, 'h10);
    // Way 2 remains hittable
    do_req(7, 'h12, 0, 1, 2, 3, -1);

    // Consumer stall for 4 cycles
    do_req(3, 'h155, 4, 1, 5, 6, -1);

    // Fill and request together: fill first, request next cycle sees the new tag
    req_valid = 1'b1; req_index = IB'(3); req_tag = 10'h0AA;
    do_fill(3, 1, 'h0AA, 2);
    chk("req_not_taken", int'(fill_retry), 0);
    do_req(3, 'h0AA, 0, 1, 1, 2, -1);

    // Reset during LOOKUP
    req_valid = 1'b1; req_index = IB'(7); req_tag = 10'h3FF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_lat = 1000; m_busy = 1'b1; n_since = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    m_busy = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_ack_valid", int'(ack_valid), 0);
    chk("midrst_req_retry", int'(req_retry), 0);
    chk("midrst_fill_retry", int'(fill_retry), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    // Everything invalid again: previously valid tags now miss on way 0
    do_req(7, 'h11, 0, 0, 0, 9, -1);
    do_req(3, 'h155, 0, 0, 0, 9, -1);

    repeat (3) @(posedge clk);
    finish_now();
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
